// File: rtl/timer_share_pkg.sv
// timer_share_pkg: shared scheduler state, mode type and timing constants
package timer_share_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} sched_state_t;

   typedef logic [1:0] tmr_mode_t;

   localparam int DUR_M0 = 32;
   localparam int DUR_M1 = 64;
   localparam int DUR_M2 = 128;
   localparam int DUR_M3 = 256;

   localparam int WDOG_CYCLES_DEF = 300;

   function automatic int mode_cycles(tmr_mode_t m);
      return DUR_M0 << m;
   endfunction

endpackage

// File: rtl/timer_rr_pick.sv
// timer_rr_pick: combinational round-robin selector, first set request at or above the pointer with wrap
module timer_rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic            any_o,
   output logic [ID_W-1:0] idx_o
);

   // scan from the farthest offset down so the request closest to the pointer wins
   always_comb begin
      any_o = |req_i;
      idx_o = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_i) + k) % N]) idx_o = ID_W'((int'(ptr_i) + k) % N);
      end
   end

endmodule

// File: rtl/timer_share_sched.sv
// timer_share_sched: round-robin sharing of one single-shot timer among NUM_REQ requesters.
// Optional: define TIMER_SHARE_SCHED_WATCHDOG_EN to abort a WAIT_DONE lasting WDOG_CYCLES cycles.
module timer_share_sched
   import timer_share_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = $clog2(NUM_REQ),
   parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [2*NUM_REQ-1:0] req_mode,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   req_done,
   output logic                 tmr_fire_valid,
   output logic [1:0]           tmr_mode,
   input  logic                 tmr_fire_ready,
   input  logic                 tmr_done,
   output logic                 sched_busy,
   output logic [ID_W-1:0]      active_id,
   output logic                 sched_err
);

   sched_state_t       state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, id_q, id_d, pick_idx;
   logic               pick_any;
   logic [NUM_REQ-1:0] ready_q, ready_d, done_q, done_d;
   logic               fire_q, fire_d, busy_q, busy_d;
   tmr_mode_t          mode_q, mode_d;

   timer_rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .any_o (pick_any),
      .idx_o (pick_idx)
   );

`ifdef TIMER_SHARE_SCHED_WATCHDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            err_q, err_d, wdog_hit;
   assign wdog_hit  = (wdog_q == WD_W'(WDOG_CYCLES - 1));
   assign sched_err = err_q;
`else
   logic [31:0] unused_wdog;
   assign unused_wdog = WDOG_CYCLES;
   assign sched_err   = 1'b0;
`endif

   // next state: arbitrate in IDLE, hold the fire request in ISSUE, await the timer in WAIT_DONE
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      mode_d   = mode_q;
      fire_d   = fire_q;
      busy_d   = busy_q;
      ready_d  = '0;
      done_d   = '0;
`ifdef TIMER_SHARE_SCHED_WATCHDOG_EN
      err_d    = 1'b0;
      wdog_d   = wdog_q;
`endif
      case (state_q)
         IDLE: if (pick_any) begin
            state_d  = ISSUE;
            id_d     = pick_idx;
            mode_d   = req_mode[{pick_idx, 1'b0} +: 2];
            rr_ptr_d = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
            ready_d  = NUM_REQ'(1) << pick_idx;
            fire_d   = 1'b1;
            busy_d   = 1'b1;
         end
         ISSUE: if (tmr_fire_ready) begin
            state_d = WAIT_DONE;
            fire_d  = 1'b0;
`ifdef TIMER_SHARE_SCHED_WATCHDOG_EN
            wdog_d  = '0;
`endif
         end
         WAIT_DONE: begin
`ifdef TIMER_SHARE_SCHED_WATCHDOG_EN
            wdog_d = wdog_q + WD_W'(1);
            if (tmr_done || wdog_hit) begin
               err_d   = !tmr_done;
`else
            if (tmr_done) begin
`endif
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = NUM_REQ'(1) << id_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // registered state and outputs; reset abandons any request in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         mode_q   <= '0;
         fire_q   <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= '0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         mode_q   <= mode_d;
         fire_q   <= fire_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
      end
   end

`ifdef TIMER_SHARE_SCHED_WATCHDOG_EN
   // watchdog counter and abort flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wdog_q <= wdog_d;
         err_q  <= err_d;
      end
   end
`endif

   assign req_ready      = ready_q;
   assign req_done       = done_q;
   assign tmr_fire_valid = fire_q;
   assign tmr_mode       = mode_q;
   assign sched_busy     = busy_q;
   assign active_id      = id_q;

endmodule

// File: tb/tb_timer_share_sched.sv
// tb_timer_share_sched: randomized scoreboard bench with a behavioural timer and transaction-level arbiter model
module tb_timer_share_sched;
   import timer_share_pkg::*;

   localparam int N  = 4;
   localparam int IW = $clog2(N);
`ifdef TIMER_SHARE_SCHED_WATCHDOG_EN
   localparam int WDOG_LIMIT = WDOG_CYCLES_DEF;
`else
   localparam int WDOG_LIMIT = 0;
`endif

   logic           clk = 1'b0, rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [2*N-1:0] req_mode = '0;
   logic [N-1:0]   req_ready, req_done;
   logic           tmr_fire_valid, tmr_fire_ready = 1'b0, tmr_done = 1'b0;
   logic [1:0]     tmr_mode;
   logic           sched_busy, sched_err;
   logic [IW-1:0]  active_id;

   int total = 0, bad = 0, cyc = 0;

   typedef struct {int cyc; int id; int mode; int err;} ev_t;
   ev_t grant_q[$], done_q[$];
   int  glog[$];

   int owner = -1, rr = 0, waited = 0, own_mode = 0;
   bit fired = 1'b0;
   bit hs = 1'b0;
   int hs_mode = 0, t_left = 0, err_seen = 0;
   bit suppress = 1'b0, hold_all = 1'b1, stall = 1'b0, quiet = 1'b0;

   timer_share_sched #(.NUM_REQ(N), .WDOG_CYCLES(WDOG_CYCLES_DEF)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_mode       (req_mode),
      .req_ready      (req_ready),
      .req_done       (req_done),
      .tmr_fire_valid (tmr_fire_valid),
      .tmr_mode       (tmr_mode),
      .tmr_fire_ready (tmr_fire_ready),
      .tmr_done       (tmr_done),
      .sched_busy     (sched_busy),
      .active_id      (active_id),
      .sched_err      (sched_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int outs_packed();
      return int'({req_ready, req_done, tmr_fire_valid, tmr_mode, sched_busy, active_id, sched_err});
   endfunction

   // reference model: one step per clock edge using the inputs present before the edge
   always @(posedge clk) begin
      cyc++;
      hs = tmr_fire_valid && tmr_fire_ready;
      hs_mode = int'(tmr_mode);
      if (rst_n) begin
         if (owner < 0) begin
            if (req_valid != '0) begin
               for (int k = N - 1; k >= 0; k--)
                  if (req_valid[(rr + k) % N]) owner = (rr + k) % N;
               own_mode = int'(req_mode[2*owner +: 2]);
               rr = (owner + 1) % N;
               fired = 1'b0;
               grant_q.push_back('{cyc, owner, own_mode, 0});
            end
         end else if (!fired) begin
            if (tmr_fire_ready) begin
               fired = 1'b1;
               waited = 0;
            end
         end else begin
            waited++;
            if (tmr_done || waited == WDOG_LIMIT) begin
               done_q.push_back('{cyc, owner, own_mode, int'(!tmr_done)});
               owner = -1;
               fired = 1'b0;
            end
         end
      end
   end

   // asynchronous reset drops every outstanding expectation
   always @(negedge rst_n) begin
      owner = -1;
      fired = 1'b0;
      rr = 0;
      grant_q.delete();
      done_q.delete();
   end

   // monitor: pop and compare whenever the DUT presents a grant or completion
   always @(negedge clk) begin
      ev_t e;
      if (!rst_n) chk("reset_outs", outs_packed(), 0);
      else begin
         if (req_ready != '0) begin
            if (grant_q.size() == 0) chk("unexpected_grant", int'(req_ready), 0);
            else begin
               e = grant_q.pop_front();
               glog.push_back(int'(active_id));
               chk("grant_cycle", cyc, e.cyc);
               chk("grant_onehot", int'(req_ready), 1 << e.id);
               chk("grant_active_id", int'(active_id), e.id);
               chk("grant_tmr_mode", int'(tmr_mode), e.mode);
            end
         end else if (grant_q.size() != 0 && grant_q[0].cyc <= cyc) begin
            chk("grant_missing", int'(req_ready), 1 << grant_q[0].id);
            void'(grant_q.pop_front());
         end
         if (req_done != '0) begin
            if (done_q.size() == 0) chk("unexpected_done", int'(req_done), 0);
            else begin
               e = done_q.pop_front();
               chk("done_cycle", cyc, e.cyc);
               chk("done_onehot", int'(req_done), 1 << e.id);
               chk("done_err", int'(sched_err), e.err);
               if (sched_err) err_seen++;
            end
         end else begin
            chk("err_idle", int'(sched_err), 0);
            if (done_q.size() != 0 && done_q[0].cyc <= cyc) begin
               chk("done_missing", int'(req_done), 1 << done_q[0].id);
               void'(done_q.pop_front());
            end
         end
         chk("fire_valid", int'(tmr_fire_valid), int'(owner >= 0 && !fired));
         chk("busy", int'(sched_busy), int'(owner >= 0));
         if (owner >= 0 && !fired) chk("issue_mode", int'(tmr_mode), own_mode);
      end
   end

   // behavioural single-shot timer and requesting agents
   always @(negedge clk) begin
      tmr_done = 1'b0;
      if (!rst_n) begin
         t_left = 0;
         tmr_fire_ready = 1'b0;
      end else begin
         if (hs) t_left = mode_cycles(tmr_mode_t'(hs_mode));
         else if (t_left > 0) begin
            t_left--;
            if (t_left == 0) tmr_done = !suppress;
         end else if (!suppress && $urandom_range(0, 40) == 0) tmr_done = 1'b1;
         tmr_fire_ready = !stall && $urandom_range(0, 2) != 0;
      end
      for (int i = 0; i < N; i++) begin
         if (hold_all) begin
            req_valid[i] = 1'b1;
            req_mode[2*i +: 2] = 2'(i);
         end else if (req_valid[i] && req_ready[i]) begin
            req_valid[i] = !quiet && $urandom_range(0, 1) == 1;
            req_mode[2*i +: 2] = 2'($urandom_range(0, 3));
         end else if (!req_valid[i] && !quiet && $urandom_range(0, 15) == 0) begin
            req_valid[i] = 1'b1;
            req_mode[2*i +: 2] = 2'($urandom_range(0, 3));
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 3000 && glog.size() < 5; t++) @(negedge clk);
      hold_all = 1'b0;
      for (int k = 0; k < 5; k++) chk("rr_order", (k < glog.size()) ? glog[k] : -1, k % N);
      repeat (4000) @(negedge clk);
      stall = 1'b1;
      for (int t = 0; t < 2000 && !(owner >= 0 && !fired); t++) @(negedge clk);
      repeat (5) @(negedge clk);
      chk("stall_fire_valid", int'(tmr_fire_valid), 1);
      stall = 1'b0;
      for (int t = 0; t < 2000 && !(owner >= 0 && fired); t++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outs", outs_packed(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3000) @(negedge clk);
`ifdef TIMER_SHARE_SCHED_WATCHDOG_EN
      suppress = 1'b1;
      repeat (1500) @(negedge clk);
      chk("wdog_seen", int'(err_seen > 0), 1);
      suppress = 1'b0;
`endif
      quiet = 1'b1;
      for (int t = 0; t < 3000 && !(req_valid == '0 && owner < 0); t++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("drain_busy", int'(sched_busy), 0);
      chk("drain_grants", grant_q.size(), 0);
      chk("drain_dones", done_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timer_share_sched.md
Name: timer_share_sched

Overview:
Round-robin scheduler that shares one single_shot_timer instance between NUM_REQ requesters. Each requester asks for a one-shot pulse with a 2-bit mode. The block then:
- grants one request at a time,
- drives the timer's fire_valid/fire_ready handshake with the granted mode,
- waits for the timer's done,
- returns a one-cycle completion pulse to the owning requester.

It sits between the requesting agents and the single timer, and is the only master of the timer's fire interface.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of the requester index
WDOG_CYCLES, 300, watchdog limit in cycles spent in WAIT_DONE; exceeds the longest mode of 256 plus margin (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request; held until accepted
req_mode  in  2*NUM_REQ  per-requester mode; requester i uses bits [2i+1:2i]; 00=32, 01=64, 10=128, 11=256 cycles
req_ready  out  NUM_REQ  one-hot, one-cycle acceptance of the granted request
req_done  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner
tmr_fire_valid  out  1  to timer fire_valid
tmr_mode  out  2  to timer mode
tmr_fire_ready  in  1  from timer fire_ready
tmr_done  in  1  from timer done
sched_busy  out  1  high from grant until the cycle after completion
active_id  out  ID_W  index of the current owner; valid while sched_busy
sched_err  out  1  one-cycle watchdog abort flag; tied 0 without the optional feature

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, and all outputs 0: req_ready, req_done, tmr_fire_valid, tmr_mode, sched_busy, active_id, sched_err. Reset mid-operation abandons the current request with no req_done. The timer shares rst_n.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - If req_valid is nonzero, select the first set bit scanning upward from rr_ptr with wrap-around.
  - On that edge: latch grant index and mode, pulse req_ready[idx] for one cycle, set sched_busy=1 and active_id=idx, set rr_ptr=(idx+1) mod NUM_REQ, go to ISSUE.
  - Requests with req_valid=0 are skipped. No pending request: stay in IDLE.
- ISSUE:
  - tmr_fire_valid=1 and tmr_mode=latched mode, held stable until tmr_fire_ready=1 at a clock edge.
  - On that handshake edge: drop tmr_fire_valid and go to WAIT_DONE.
  - tmr_mode holds its last value when not issuing.
- WAIT_DONE:
  - On tmr_done=1: pulse req_done[idx] on the next cycle, clear sched_busy on that same edge, and go to IDLE.
  - tmr_done seen in IDLE or ISSUE is ignored (stale).
- Latency:
  - req_valid high in IDLE → req_ready on the next edge.
  - tmr_fire_valid asserted on that same edge.
  - req_done follows tmr_done by 1 cycle.
- Back-to-back: in the cycle req_done pulses the block is in IDLE and may grant again. Turnaround from tmr_done to the next tmr_fire_valid is 2 cycles.
- Fairness: the requester just served has lowest priority at the next arbitration. Simultaneous requests from all NUM_REQ are served in index order starting at rr_ptr.
- req_valid dropping after acceptance has no effect. req_mode is sampled only at the grant edge.
- A single requester may re-request immediately; it is regranted when no other requester is pending.

Optional Feature:
TIMER_SHARE_SCHED_WATCHDOG_EN:
- Defined: a counter runs in WAIT_DONE. If WDOG_CYCLES elapse without tmr_done, the block goes to IDLE and pulses sched_err together with req_done[idx]. The counter is cleared on entry to WAIT_DONE.
- Undefined: no counter; the block waits indefinitely; sched_err is constant 0.

Decomposition:
- Package timer_share_pkg:
  - state enum sched_state_t {IDLE, ISSUE, WAIT_DONE}
  - mode typedef tmr_mode_t (logic [1:0])
  - duration constants DUR_M0..DUR_M3 = 32/64/128/256 for benches
  - default WDOG_CYCLES
- Sub-module timer_rr_pick: combinational round-robin selector. Inputs: req vector, rr_ptr. Outputs: any-valid flag, grant index.

Test Plan:
1. Reset with req_valid=4'b0001 and mode 00 → req_ready[0] one cycle after release, tmr_fire_valid the same cycle; timer done after 32+ cycles → req_done[0] exactly 1 cycle after tmr_done.
2. req_valid=4'b1111 held, modes 00/01/10/11 → grant order 0,1,2,3,0. Each tmr_mode matches the owner; req_done is one-hot to the correct index each time.
3. Requester 2 re-requests continuously while requester 0 arrives mid-service → next grant is 0 (rr_ptr=3 wraps), then 2.
4. tmr_fire_ready held 0 for 5 cycles in ISSUE → tmr_fire_valid and tmr_mode stay stable for all 5 cycles; the handshake completes on the first ready edge.
5. Reset asserted during WAIT_DONE → all outputs 0 immediately (async), no req_done; after release, pending requests are rearbitrated from index 0.
6. With TIMER_SHARE_SCHED_WATCHDOG_EN and tmr_done suppressed → sched_err and req_done[idx] pulse WDOG_CYCLES=300 cycles after WAIT_DONE entry, then the block is back in IDLE.
